// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32 pipeline: owns the PC, issues
// addresses to a 1-cycle-latency synchronous instruction memory and presents
// each returned instruction together with its PC to Decode.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   StallF     hold fetch; PC and presented outputs frozen
//   PCSrcE     redirect request from Execute
//   PCTargetE  redirect target (bits [1:0] forced to 00)
//   ImemAddr   address issued to instruction memory this cycle (registered)
//   ImemRdata  instruction for the address issued in the previous cycle
//   InstrF     presented instruction (NOP_INSTR when ValidF=0)
//   PCF        PC of InstrF (0 when ValidF=0)
//   PCPlus4F   PCF+4 modulo 2^WIDTH (0 when ValidF=0)
//   ValidF     presented fetch is real and on the correct path
module fetch_stage #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    output logic [WIDTH-1:0] ImemAddr,
    input  logic [WIDTH-1:0] ImemRdata,
    output logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic             ValidF
);

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    // Issued address and the address/validity of the word returning now
    logic [WIDTH-1:0] pc_req;
    logic [WIDTH-1:0] pc_resp;
    logic             resp_valid;

    // Stall skid buffer: freezes what was presented when the stall began,
    // since the memory keeps returning a newer word while PC is held
    logic [WIDTH-1:0] hold_instr;
    logic [WIDTH-1:0] hold_pc;
    logic             hold_valid;
    logic             hold_active;

    // Raw presented values before bubble masking
    logic [WIDTH-1:0] pres_instr;
    logic [WIDTH-1:0] pres_pc;
    logic             pres_valid;

    // Select between live memory response and the skid buffer
    always_comb begin
        pres_instr = ImemRdata;
        pres_pc    = pc_resp;
        pres_valid = resp_valid;
        if (hold_active) begin
            pres_instr = hold_instr;
            pres_pc    = hold_pc;
            pres_valid = hold_valid;
        end
    end

    // Bubbles present a canonical NOP with zeroed PCs
    always_comb begin
        InstrF   = NOP_INSTR;
        PCF      = '0;
        PCPlus4F = '0;
        ValidF   = pres_valid;
        if (pres_valid) begin
            InstrF   = pres_instr;
            PCF      = pres_pc;
            PCPlus4F = pres_pc + PC_STEP;
        end
    end

    assign ImemAddr = pc_req;

    // PC / response tracking; priority rst > redirect > stall > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_req      <= RESET_PC;
            pc_resp     <= '0;
            resp_valid  <= 1'b0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            hold_valid  <= 1'b0;
            hold_active <= 1'b0;
        end else if (PCSrcE) begin
            // Word returning next cycle is wrong-path: mark it invalid
            pc_req      <= PCTargetE & ALIGN_MASK;
            resp_valid  <= 1'b0;
            hold_active <= 1'b0;
        end else if (StallF) begin
            if (!hold_active) begin
                hold_instr  <= pres_instr;
                hold_pc     <= pres_pc;
                hold_valid  <= pres_valid;
                hold_active <= 1'b1;
            end
        end else begin
            // Held pc_req is re-issued on release, so nothing is lost
            pc_req      <= pc_req + PC_STEP;
            pc_resp     <= pc_req;
            resp_valid  <= 1'b1;
            hold_active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, stall, redirect, stall+redirect,
// PC wrap (second instance with high RESET_PC) and reset during a stall.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        rst_w;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;

    logic [31:0] ImemAddr, ImemRdata, InstrF, PCF, PCPlus4F;
    logic        ValidF;
    logic [31:0] w_ImemAddr, w_ImemRdata, w_InstrF, w_PCF, w_PCPlus4F;
    logic        w_ValidF;

    int n_cmp;
    int n_err;

    fetch_stage dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst_w), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ImemAddr(w_ImemAddr), .ImemRdata(w_ImemRdata),
        .InstrF(w_InstrF), .PCF(w_PCF), .PCPlus4F(w_PCPlus4F), .ValidF(w_ValidF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: mem[a] = a | 0x13
    always @(posedge clk) begin
        ImemRdata   <= ImemAddr | 32'h13;
        w_ImemRdata <= w_ImemAddr | 32'h13;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle with rst=0
    task automatic do_reset();
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0;
        step();
        n_cmp++; if ({ValidF, InstrF} !== {1'b0, 32'h13}) begin n_err++; $display("FAIL rst_cyc1 got v=%b i=%h exp v=0 i=00000013", ValidF, InstrF); end
        step();
        n_cmp++; if ({ValidF, InstrF, PCF, PCPlus4F} !== {1'b0, 32'h13, 32'h0, 32'h0}) begin n_err++; $display("FAIL rst_cyc2 got v=%b i=%h pc=%h p4=%h", ValidF, InstrF, PCF, PCPlus4F); end
        rst = 1'b0;
        n_cmp++; if ({ValidF, ImemAddr} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL rst_release got v=%b addr=%h exp v=0 addr=0", ValidF, ImemAddr); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] pc;
            pc = 32'(k * 4);
            step();
            n_cmp++; if ({ValidF, PCF, PCPlus4F, InstrF} !== {1'b1, pc, pc + 32'd4, pc | 32'h13}) begin n_err++; $display("FAIL rst_seq%0d got v=%b pc=%h p4=%h i=%h exp pc=%h", k, ValidF, PCF, PCPlus4F, InstrF, pc); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        // PCF=8 now; stall 3 cycles then release cycle, all present PC 8
        for (int k = 0; k < 4; k++) begin
            StallF = (k < 3);
            n_cmp++; if ({ValidF, PCF, InstrF} !== {1'b1, 32'h8, 32'h1B}) begin n_err++; $display("FAIL stall_hold%0d got v=%b pc=%h i=%h exp pc=8 i=1b", k, ValidF, PCF, InstrF); end
            step();
        end
        StallF = 1'b0;
        n_cmp++; if ({ValidF, PCF, InstrF} !== {1'b1, 32'hC, 32'h1F}) begin n_err++; $display("FAIL stall_next got v=%b pc=%h i=%h exp pc=c i=1f", ValidF, PCF, InstrF); end
        step();
        n_cmp++; if ({ValidF, PCF, PCPlus4F} !== {1'b1, 32'h10, 32'h14}) begin n_err++; $display("FAIL stall_next2 got v=%b pc=%h p4=%h exp pc=10 p4=14", ValidF, PCF, PCPlus4F); end
    endtask

    task automatic test_redirect();
        do_reset();
        step(); step(); step();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        n_cmp++; if ({ValidF, InstrF, PCF, ImemAddr} !== {1'b0, 32'h13, 32'h0, 32'h100}) begin n_err++; $display("FAIL redir_t1 got v=%b i=%h pc=%h addr=%h", ValidF, InstrF, PCF, ImemAddr); end
        step();
        n_cmp++; if ({ValidF, PCF, PCPlus4F, InstrF} !== {1'b1, 32'h100, 32'h104, 32'h113}) begin n_err++; $display("FAIL redir_t2 got v=%b pc=%h p4=%h i=%h exp pc=100", ValidF, PCF, PCPlus4F, InstrF); end
        // Back-to-back: only the last target appears
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCTargetE = 32'h180;
        step();
        PCSrcE = 1'b0;
        n_cmp++; if (ValidF !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got v=%b exp 0", ValidF); end
        step();
        n_cmp++; if ({ValidF, PCF} !== {1'b1, 32'h180}) begin n_err++; $display("FAIL b2b_target got v=%b pc=%h exp pc=180", ValidF, PCF); end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        step(); step();
        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h203;
        step();
        StallF = 1'b0; PCSrcE = 1'b0;
        n_cmp++; if ({ValidF, ImemAddr} !== {1'b0, 32'h200}) begin n_err++; $display("FAIL sr_t1 got v=%b addr=%h exp v=0 addr=200", ValidF, ImemAddr); end
        step();
        n_cmp++; if ({ValidF, PCF, InstrF} !== {1'b1, 32'h200, 32'h213}) begin n_err++; $display("FAIL sr_t2 got v=%b pc=%h i=%h exp pc=200", ValidF, PCF, InstrF); end
        // Stall on the bubble after a redirect keeps the bubble
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        PCSrcE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            StallF = (k < 2);
            n_cmp++; if ({ValidF, InstrF, PCF} !== {1'b0, 32'h13, 32'h0}) begin n_err++; $display("FAIL bubble_hold%0d got v=%b i=%h pc=%h exp v=0", k, ValidF, InstrF, PCF); end
            step();
        end
        StallF = 1'b0;
        n_cmp++; if ({ValidF, PCF, InstrF} !== {1'b1, 32'h300, 32'h313}) begin n_err++; $display("FAIL bubble_rel got v=%b pc=%h i=%h exp pc=300", ValidF, PCF, InstrF); end
        step();
        n_cmp++; if ({ValidF, PCF} !== {1'b1, 32'h304}) begin n_err++; $display("FAIL bubble_rel2 got v=%b pc=%h exp pc=304", ValidF, PCF); end
    endtask

    task automatic test_wrap();
        StallF = 1'b0; PCSrcE = 1'b0;
        rst_w = 1'b1;
        step(); step();
        rst_w = 1'b0;
        n_cmp++; if ({w_ValidF, w_ImemAddr} !== {1'b0, 32'hFFFF_FFF8}) begin n_err++; $display("FAIL wrap_rel got v=%b addr=%h exp addr=fffffff8", w_ValidF, w_ImemAddr); end
        step();
        n_cmp++; if ({w_ValidF, w_PCF, w_PCPlus4F} !== {1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL wrap_0 got v=%b pc=%h p4=%h", w_ValidF, w_PCF, w_PCPlus4F); end
        step();
        n_cmp++; if ({w_ValidF, w_PCF, w_PCPlus4F, w_InstrF} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL wrap_1 got v=%b pc=%h p4=%h i=%h", w_ValidF, w_PCF, w_PCPlus4F, w_InstrF); end
        step();
        n_cmp++; if ({w_ValidF, w_PCF, w_PCPlus4F} !== {1'b1, 32'h0, 32'h4}) begin n_err++; $display("FAIL wrap_2 got v=%b pc=%h p4=%h exp pc=0 p4=4", w_ValidF, w_PCF, w_PCPlus4F); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        step(); step(); step();
        StallF = 1'b1;
        step();
        n_cmp++; if ({ValidF, PCF} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL rms_stall got v=%b pc=%h exp pc=8", ValidF, PCF); end
        rst = 1'b1;
        step();
        rst = 1'b0; StallF = 1'b0;
        n_cmp++; if ({ValidF, PCF, InstrF, ImemAddr} !== {1'b0, 32'h0, 32'h13, 32'h0}) begin n_err++; $display("FAIL rms_reset got v=%b pc=%h i=%h addr=%h", ValidF, PCF, InstrF, ImemAddr); end
        step();
        n_cmp++; if ({ValidF, PCF} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL rms_restart0 got v=%b pc=%h exp pc=0", ValidF, PCF); end
        step();
        n_cmp++; if ({ValidF, PCF, InstrF} !== {1'b1, 32'h4, 32'h17}) begin n_err++; $display("FAIL rms_restart1 got v=%b pc=%h i=%h exp pc=4", ValidF, PCF, InstrF); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; rst_w = 1'b1;
        StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        test_reset();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_wrap();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
